// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//
// Purpose: bundles the request/response signals between a core's data-access
// port and the data_mem_responder.
//
// Signals:
//   req_valid    core -> mem   core presents a request
//   req_ready    mem  -> core  responder can accept (high only when idle)
//   req_we       core -> mem   1 = store, 0 = load
//   req_addr     core -> mem   byte address
//   req_wdata    core -> mem   store data (low byte/half used for sub-word stores)
//   req_size     core -> mem   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned core -> mem   loads only: 1 = zero-extend, 0 = sign-extend
//   rsp_valid    mem  -> core  response available
//   rsp_ready    core -> mem   core consumes the response
//   rsp_rdata    mem  -> core  extended load result, 0 for stores and errors
//   rsp_err      mem  -> core  misaligned / out-of-range / illegal-size access
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload steady until that edge, and
// may not withdraw valid once raised; ready may toggle freely. The request
// channel payload is req_*, the response channel payload is rsp_rdata/rsp_err.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose: memory-side responder for a core's data-access port. Accepts one
// RV32I load/store at a time, waits WAIT_CYCLES wait states, performs the RAM
// access and returns a sized/extended response. Misaligned (trap build),
// out-of-range and illegal-size accesses are reported with rsp_err and never
// modify memory.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    byte address mapped to word 0 (word aligned)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   bus        slave modport of data_mem_responder_if (request/response)
//   dbg_state  out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Configuration macro MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses give rsp_err=1, rdata=0, no write
//   undefined - low address bits are forced to alignment and the access
//               completes normally
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    data_mem_responder_if.slave   bus,
    output logic [1:0]            dbg_state
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [3:0]  LAST_CNT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    // Access operands. With WAIT_CYCLES=0 the RAM access happens on the accept
    // edge itself, so the live request is used while idle; otherwise the
    // captured copy is used.
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_uns;

    logic [31:0]      off;
    logic             oor;
    logic             bad_size;
    logic             misaligned;
    logic             acc_err;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      rd_word;
    logic [31:0]      shifted;
    logic [31:0]      load_val;
    logic             enter_resp;
    logic             mem_we;
    logic             unused_bits;

    always_comb begin
        if (state_q == S_IDLE) begin
            a_we    = bus.req_we;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_size  = bus.req_size;
            a_uns   = bus.req_unsigned;
        end else begin
            a_we    = we_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
            a_size  = size_q;
            a_uns   = uns_q;
        end
    end

    // Address decode and error classification.
    always_comb begin
        off        = a_addr - BASE_ADDR;
        oor        = (a_addr < BASE_ADDR) || ({2'b00, off[31:2]} >= DEPTH_W);
        bad_size   = (a_size == 2'b11);
        misaligned = ((a_size == 2'b01) && a_addr[0]) ||
                     ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
        idx        = off[IDX_W+1:2];
`ifdef MISALIGN_TRAP_EN
        acc_err = oor || bad_size || misaligned;
        lane    = a_addr[1:0];
`else
        acc_err = oor || bad_size;
        case (a_size)
            2'b01:   lane = {a_addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = a_addr[1:0];
        endcase
`endif
    end

    // Store byte enables; data is replicated so every lane sees its byte.
    always_comb begin
        case (a_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << lane;
                wd = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = a_wdata;
            end
            default: begin
                be = 4'b0000;
                wd = 32'h0;
            end
        endcase
    end

    // Load path: shift the addressed lane down, then extend.
    always_comb begin
        rd_word = mem[idx];
        shifted = rd_word >> {lane, 3'b000};
        case (a_size)
            2'b00:   load_val = a_uns ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = a_uns ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            2'b10:   load_val = rd_word;
            default: load_val = 32'h0;
        endcase
    end

    assign unused_bits = ^{off[1:0], shifted[31:16], misaligned};

    // FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (a_we || acc_err) ? 32'h0 : load_val;
        end
    end

    // reset_n gating keeps a live request from writing while reset is held.
    assign mem_we = enter_resp && a_we && !acc_err && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM array: not reset, contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) begin
                mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
module tb_data_mem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WAITC = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem_b [0:4*DEPTH-1];
  logic [32:0] exp_q [$];
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_lat;
  logic        obs_stable;

  // Reference model: byte-addressed memory, returns {err, rdata}.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [1:0] size,
                                               input logic uns);
    int          nb;
    longint      off;
    logic [31:0] a;
    logic [31:0] val;
    logic        err;
    err = 1'b0;
    val = 32'h0;
    nb  = 1 << size;
    a   = addr;
    if (size == 2'b11) err = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((addr % nb) != 0) err = 1'b1;
`else
    a = addr - 32'(addr % nb);
`endif
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    if (off < 0 || off >= 4 * DEPTH) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_b[int'(off) + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) val[8*i +: 8] = mem_b[int'(off) + i];
        if (nb < 4 && !uns && val[8*nb-1])
          for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
      end
    end
    if (we || err) val = 32'h0;
    return {err, val};
  endfunction

  // ---------------- driver ----------------
  // Starts and ends at a negedge. Holds rsp_ready low for 'hold' cycles of RESP.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold);
    int t;
    int k;
    exp_q.push_back(model_access(we, addr, wdata, size, uns));
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!bus.req_ready) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, t);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!bus.rsp_valid) begin
      n_bad++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", bus.rsp_valid, k);
    end
    obs_lat    = k + 1;
    obs_rdata  = bus.rsp_rdata;
    obs_err    = bus.rsp_err;
    obs_stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== obs_rdata || bus.rsp_err !== obs_err || bus.req_ready)
        obs_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, dbg_state} !== {3'b100, 32'h0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_held: rdy=%0b vld=%0b err=%0b rdata=%h st=%0d, required 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, dbg_state);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_idle: rdy=%0b vld=%0b err=%0b rdata=%h, required 1 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
  endtask

  task automatic test_word;
    logic [32:0] e;
    do_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e || obs_lat != 1 + WAITC) begin
      n_bad++;
      $display("FAIL sw: err=%0b rdata=%h lat=%0d, required err=%0b rdata=%h lat=%0d",
               obs_err, obs_rdata, obs_lat, e[32], e[31:0], 1 + WAITC);
    end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== {1'b0, 32'hDEAD_BEEF} || e !== {1'b0, 32'hDEAD_BEEF} || obs_lat != 1 + WAITC) begin
      n_bad++;
      $display("FAIL lw: err=%0b rdata=%h lat=%0d, required err=0 rdata=deadbeef lat=%0d",
               obs_err, obs_rdata, obs_lat, 1 + WAITC);
    end
  endtask

  task automatic test_byte;
    logic [32:0] e;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FF80;
    want[1] = 32'h0000_0080;
    want[2] = 32'hDEAD_80EF;
    do_txn(1'b1, 32'h8000_0011, 32'h0000_0080, 2'b00, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e) begin
      n_bad++;
      $display("FAIL sb: err=%0b rdata=%h, required err=%0b rdata=%h", obs_err, obs_rdata, e[32], e[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, (i == 2) ? 32'h8000_0010 : 32'h8000_0011, 32'h0,
             (i == 2) ? 2'b10 : 2'b00, (i == 1), 0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_err, obs_rdata} !== {1'b0, want[i]} || e !== {1'b0, want[i]}) begin
        n_bad++;
        $display("FAIL byte_load_%0d: err=%0b rdata=%h, required err=0 rdata=%h", i, obs_err, obs_rdata, want[i]);
      end
    end
  endtask

  task automatic test_misalign;
    logic [32:0] e;
    logic        want_err;
    logic [31:0] want_word;
`ifdef MISALIGN_TRAP_EN
    want_err  = 1'b1;
    want_word = 32'hDEAD_80EF;
`else
    want_err  = 1'b0;
    want_word = 32'h1234_80EF;
`endif
    do_txn(1'b1, 32'h8000_0013, 32'h0000_1234, 2'b01, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== {want_err, 32'h0} || e !== {want_err, 32'h0}) begin
      n_bad++;
      $display("FAIL sh_misaligned: err=%0b rdata=%h, required err=%0b rdata=0", obs_err, obs_rdata, want_err);
    end
    do_txn(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== {1'b0, want_word} || e !== {1'b0, want_word}) begin
      n_bad++;
      $display("FAIL sh_readback: err=%0b rdata=%h, required err=0 rdata=%h", obs_err, obs_rdata, want_word);
    end
  endtask

  task automatic test_range;
    logic [32:0] e;
    logic [31:0] addrs [4];
    logic        wes [4];
    logic        errs [4];
    addrs[0] = BASE + 32'(4 * DEPTH - 4); wes[0] = 1'b1; errs[0] = 1'b0;
    addrs[1] = BASE + 32'(4 * DEPTH - 4); wes[1] = 1'b0; errs[1] = 1'b0;
    addrs[2] = BASE + 32'(4 * DEPTH);     wes[2] = 1'b0; errs[2] = 1'b1;
    addrs[3] = 32'h7FFF_FFFC;             wes[3] = 1'b0; errs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_txn(wes[i], addrs[i], 32'h5A5A_0001, 2'b10, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_err, obs_rdata} !== e || obs_err !== errs[i] || (i == 1 && obs_rdata !== 32'h5A5A_0001)) begin
        n_bad++;
        $display("FAIL range_%0d: addr=%h err=%0b rdata=%h, required err=%0b rdata=%h",
                 i, addrs[i], obs_err, obs_rdata, e[32], e[31:0]);
      end
    end
    // Illegal size: error and no write to the last word.
    do_txn(1'b1, BASE + 32'(4 * DEPTH - 4), 32'hFFFF_FFFF, 2'b11, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL size11: err=%0b rdata=%h, required err=1 rdata=0", obs_err, obs_rdata);
    end
    do_txn(1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e || obs_rdata !== 32'h5A5A_0001) begin
      n_bad++;
      $display("FAIL size11_nowrite: rdata=%h, required %h", obs_rdata, e[31:0]);
    end
  endtask

  task automatic test_hold;
    logic [32:0] e;
    do_txn(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 5);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e || obs_stable !== 1'b1) begin
      n_bad++;
      $display("FAIL hold: err=%0b rdata=%h stable=%0b, required err=%0b rdata=%h stable=1",
               obs_err, obs_rdata, obs_stable, e[32], e[31:0]);
    end
  endtask

  task automatic test_reset_wait;
    logic [32:0] e;
    bus.req_we = 1'b1; bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'hCAFE_F00D;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_in_wait: rdy=%0b vld=%0b err=%0b rdata=%h, required 1 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e) begin
      n_bad++;
      $display("FAIL dropped_store: rdata=%h, required %h", obs_rdata, e[31:0]);
    end
  endtask

  task automatic test_reset_resp;
    logic [32:0] e;
    int          k;
    e = model_access(1'b1, 32'h8000_0014, 32'h0BAD_C0DE, 2'b10, 1'b0);
    bus.req_we = 1'b1; bus.req_addr = 32'h8000_0014; bus.req_wdata = 32'h0BAD_C0DE;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (k >= 50 || {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_in_resp: wait=%0d rdy=%0b vld=%0b err=%0b, required resp reached then 1 0 0",
               k, bus.req_ready, bus.rsp_valid, bus.rsp_err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 32'h8000_0014, 32'h0, 2'b10, 1'b0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_err, obs_rdata} !== e || obs_rdata !== 32'h0BAD_C0DE) begin
      n_bad++;
      $display("FAIL kept_store: rdata=%h, required 0badc0de", obs_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e;
    int          acc [$];
    int          n_vld;
    int          want_acc;
    int          want_vld;
    int          t;
    e = model_access(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0);
    bus.req_we = 1'b0; bus.req_addr = 32'h8000_0010; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    n_vld = 0;
    want_acc = 0;
    want_vld = 0;
    for (int i = 0; i < 14; i++) begin
      if (i % (2 + WAITC) == 0) want_acc++;
      if (i % (2 + WAITC) == 1 + WAITC) want_vld++;
      if (bus.req_ready) acc.push_back(i);
      if (bus.rsp_valid) begin
        n_vld++;
        n_cmp++;
        if ({bus.rsp_err, bus.rsp_rdata} !== e) begin
          n_bad++;
          $display("FAIL b2b_data: cycle %0d rdata=%h, required %h", i, bus.rsp_rdata, e[31:0]);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (acc.size() != want_acc || n_vld != want_vld || acc.size() < 2 || acc[1] - acc[0] != 2 + WAITC) begin
      n_bad++;
      $display("FAIL b2b_rate: accepts=%0d responses=%0d, required %0d accepts spaced %0d, %0d responses",
               acc.size(), n_vld, want_acc, 2 + WAITC, want_vld);
    end
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [32:0] e;
    logic [31:0] addr;
    logic [1:0]  size;
    int          r;
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b1, BASE + 32'(4 * i), $urandom, 2'b10, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_err, obs_rdata} !== e) begin
        n_bad++;
        $display("FAIL prefill_%0d: err=%0b rdata=%h, required err=%0b rdata=%h", i, obs_err, obs_rdata, e[32], e[31:0]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE - 32'($urandom_range(1, 8));
      else if (r == 1) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else             addr = BASE + 32'($urandom_range(0, 63));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom_range(0, 1)), addr, $urandom, size, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_err, obs_rdata} !== e || obs_lat != 1 + WAITC || obs_stable !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_%0d: addr=%h size=%0d err=%0b rdata=%h lat=%0d, required err=%0b rdata=%h lat=%0d",
                 i, addr, size, obs_err, obs_rdata, obs_lat, e[32], e[31:0], 1 + WAITC);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_range();
    test_hold();
    test_reset_wait();
    test_reset_resp();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
